async_fifo_wr_arbiter: RTL and testbench
========================================

// Module: async_fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter that shares the async FIFO write side among NUM_REQ producers in the wclk domain.
//  Grants one requester at a time for a burst of up to MAX_BURST writes and drives fifo_winc/fifo_wdata.
//  Honours fifo_wfull so no write is ever issued while the FIFO is full. Sits directly in front of the FIFO write port.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..16)
//  DATA_WIDTH  8   FIFO data width, matches the FIFO write port
//  MAX_BURST   4   max writes per grant before forced rotation (>=1)
//  CNT_WIDTH   16  width of statistics counters (STATS build only)
// PORTS
//  wclk         in   1                   write-domain clock
//  wrst         in   1                   async reset, active-high
//  req_valid    in   NUM_REQ             requester i has a word pending
//  req_data     in   NUM_REQ*DATA_WIDTH  word of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ             one-hot; word of requester i accepted this cycle when valid&ready
//  fifo_wfull   in   1                   FIFO full flag (wclk domain)
//  fifo_winc    out  1                   write strobe to FIFO
//  fifo_wdata   out  DATA_WIDTH          write data to FIFO
//  grant_valid  out  1                   a burst owner is active
//  grant_id     out  $clog2(NUM_REQ)     current owner index
// BEHAVIOUR
//  Reset (wrst=1, async): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0; req_ready=0, fifo_winc=0, fifo_wdata=0,
//   grant_valid=0, grant_id=0. Reset mid-burst aborts the burst; no write is issued in the reset cycle.
//  FSM states IDLE, BURST.
//  IDLE: if |req_valid, owner <= first valid index searching from rr_ptr upward, wrapping at NUM_REQ-1;
//   burst_cnt<=0; -> BURST. Else stay. No write in IDLE (1-cycle arbitration bubble).
//  BURST: grant_valid=1, grant_id=owner.
//   req_ready[owner] = !fifo_wfull (combinational); all other ready bits 0.
//   fifo_winc = req_valid[owner] & req_ready[owner]; fifo_wdata = req_data[owner] when winc, else holds last value.
//   Each write: burst_cnt++.
//   Release -> IDLE with rr_ptr <= (owner+1) mod NUM_REQ when:
//    (a) a write occurs with burst_cnt==MAX_BURST-1, or
//    (b) req_valid[owner]==0 in a cycle with fifo_wfull==0.
//   fifo_wfull=1: no write, burst_cnt frozen, grant held regardless of req_valid (no release while full).
//  Fairness: any continuously-valid requester is granted within NUM_REQ-1 other bursts.
//  Throughput: MAX_BURST writes per MAX_BURST+1 cycles with a single active requester.
//  fifo_winc is never 1 while fifo_wfull=1; req_ready is at most one-hot.
//  Widths: burst_cnt is $clog2(MAX_BURST+1) bits; rr_ptr/owner are $clog2(NUM_REQ) bits; wrap uses explicit compare
//   with NUM_REQ-1, not power-of-two overflow.
// CONFIGURATION
//  ASYNC_FIFO_ARB_STATS_EN defined: extra ports
//   wr_count  out NUM_REQ*CNT_WIDTH  per-requester accepted writes
//   stall_cnt out CNT_WIDTH          BURST cycles with fifo_wfull=1
//   All counters reset to 0, saturate at all-ones, never wrap.
//  Not defined: no extra ports or counters; arbitration behaviour identical.
// STRUCTURE
//  Package async_fifo_arb_pkg: typedef enum logic {IDLE, BURST} arb_state_e; localparam helpers for index and
//   burst-counter widths.
//  Sub-module async_fifo_rr_picker: combinational find-first-set of req_valid rotated by rr_ptr;
//   outputs found flag and index.
//  Top holds FSM, rr_ptr, owner, burst_cnt, output muxing and optional stats.
// TESTING
//  T1 reset: assert wrst mid-burst (owner=2, burst_cnt=2) -> next edge all outputs 0, state IDLE, rr_ptr=0.
//  T2 rotation: NUM_REQ=4, all req_valid=1, wfull=0 -> grant_id 0,1,2,3,0; 4 writes per grant; 1 idle cycle between.
//  T3 full stall: owner 1 after 2 writes, wfull=1 for 5 cycles -> winc=0, req_ready=0, grant_id stays 1;
//   wfull=0 -> remaining 2 writes then rotate to 2.
//  T4 early release: only req 3 valid, deasserts after 2 words -> IDLE, rr_ptr=0; data 0xA1,0xA2 in order.
//  T5 skip idle: req_valid=4'b1010, rr_ptr=0 -> grant 1, then 3, then 1.
//  T6 stats (ASYNC_FIFO_ARB_STATS_EN, CNT_WIDTH=4): 20 writes from req 0 -> wr_count[0]=15 (saturated);
//   3 full cycles -> stall_cnt=3.

Source files
------------

// File: rtl/async_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_arb_pkg
// Shared types and width helpers for the async FIFO write-port arbiter.
//   arb_state_e      : arbiter FSM state (IDLE = arbitrate, BURST = owner writes)
//   idx_width()      : bits needed for a requester index
//   burst_cnt_width(): bits needed to count 0..MAX_BURST writes
// ---------------------------------------------------------------------------
package async_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/async_fifo_rr_picker.sv
// ---------------------------------------------------------------------------
// async_fifo_rr_picker
// Combinational round-robin pick: first set bit of req_valid_i searching
// upward from rr_ptr_i and wrapping after NUM_REQ-1.
// Ports:
//   req_valid_i  in  NUM_REQ  pending requests
//   rr_ptr_i     in  IDX_W    search start index (always < NUM_REQ)
//   found_o      out 1        at least one request pending
//   idx_o        out IDX_W    selected requester index
// ---------------------------------------------------------------------------
module async_fifo_rr_picker
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     ofs;
  logic [IDX_W:0]       sum;

  // Rotating the doubled vector right by rr_ptr puts rr_ptr at bit 0.
  assign dbl = {req_valid_i, req_valid_i} >> rr_ptr_i;
  assign rot = dbl[NUM_REQ-1:0];

  // Downward scan so the lowest set offset wins.
  always_comb begin
    ofs = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) ofs = IDX_W'(j);
    end
  end

  // Map the offset back to an absolute index; NUM_REQ need not be a power of two.
  always_comb begin
    sum = {1'b0, rr_ptr_i} + {1'b0, ofs};
    if (sum >= NREQ) sum = sum - NREQ;
  end

  assign found_o = |req_valid_i;
  assign idx_o   = sum[IDX_W-1:0];

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_arbiter
// Round-robin arbiter sharing an async FIFO write port among NUM_REQ
// producers in the wclk domain. An owner keeps the port for up to MAX_BURST
// writes; no write is ever issued while fifo_wfull is high.
// Optional build macro: ASYNC_FIFO_ARB_STATS_EN adds saturating per-requester
// write counters (wr_count) and a full-stall cycle counter (stall_cnt).
// Ports:
//   wclk, wrst         clock, async active-high reset
//   req_valid/req_data producer words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready          one-hot accept to the current owner
//   fifo_wfull         FIFO full flag
//   fifo_winc/wdata    FIFO write strobe and data
//   grant_valid/id     burst owner active / owner index
//   wr_count/stall_cnt statistics (stats build only)
//
//   state | meaning
//   IDLE  | arbitration bubble, pick next owner from rr_ptr
//   BURST | owner writes while FIFO not full
// ---------------------------------------------------------------------------
module async_fifo_wr_arbiter
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_wfull,
  output logic                          fifo_winc,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [idx_width(NUM_REQ)-1:0] grant_id
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]          stall_cnt
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int BCW   = burst_cnt_width(MAX_BURST);
  localparam logic [BCW-1:0]   LAST_CNT = BCW'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      owner_q;
  logic [BCW-1:0]        burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  release_c;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  async_fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .found_o     (pick_found),
    .idx_o       (pick_idx)
  );

  // Ready depends on wfull combinationally so a full FIFO blocks the write in the same cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == BURST && !fifo_wfull) req_ready[owner_q] = 1'b1;
  end

  assign owner_data  = data_a[owner_q];
  assign fifo_winc   = req_valid[owner_q] & req_ready[owner_q];
  assign fifo_wdata  = fifo_winc ? owner_data : wdata_q;
  assign grant_valid = (state_q == BURST);
  assign grant_id    = owner_q;

  assign burst_cnt_d = burst_cnt_q + BCW'(1);
  assign rr_ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  // While full nothing moves: no write, no count, no release.
  assign release_c = (state_q == BURST) && !fifo_wfull &&
                     (!req_valid[owner_q] || (fifo_winc && burst_cnt_q == LAST_CNT));

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (fifo_winc) begin
            wdata_q     <= owner_data;
            burst_cnt_q <= burst_cnt_d;
          end
          if (release_c) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0]   accept;
  logic [CNT_WIDTH-1:0] stall_q;

  assign accept = req_valid & req_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wr_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) cnt_q <= '0;
      else if (accept[g] && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
    assign wr_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) stall_q <= '0;
    else if (state_q == BURST && fifo_wfull && stall_q != '1) stall_q <= stall_q + CNT_WIDTH'(1);
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
module tb_async_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 4;

  logic            wclk = 1'b0;
  logic            wrst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wfull;
  logic            fifo_winc;
  logic [DW-1:0]   fifo_wdata;
  logic            grant_valid;
  logic [1:0]      grant_id;
`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [N*CW-1:0] wr_count;
  logic [CW-1:0]   stall_cnt;
`endif

  always #5 wclk = ~wclk;

  async_fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    .CNT_WIDTH  (CW)
`endif
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wfull  (fifo_wfull),
    .fifo_winc   (fifo_winc),
    .fifo_wdata  (fifo_wdata),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    .wr_count    (wr_count),
    .stall_cnt   (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] dat [N];

  // Behavioural reference: who owns the port, how many words it has written,
  // where the next search starts, and the last word handed to the FIFO.
  int            m_busy, m_owner, m_cnt, m_rr;
  logic [DW-1:0] m_last;
  logic          e_gv, e_winc;
  int            e_gid;
  logic [N-1:0]  e_ready;
  logic [DW-1:0] e_wdata;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0; m_last = '0;
  endtask

  task automatic model_outputs();
    e_gv    = (m_busy != 0);
    e_gid   = m_owner;
    e_ready = (m_busy != 0 && !fifo_wfull) ? N'(1 << m_owner) : '0;
    e_winc  = (m_busy != 0) && !fifo_wfull && req_valid[m_owner];
    e_wdata = e_winc ? dat[m_owner] : m_last;
  endtask

  task automatic model_update();
    if (m_busy == 0) begin
      if (req_valid != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (!fifo_wfull) begin
      if (req_valid[m_owner]) begin
        m_last = dat[m_owner];
        m_cnt++;
        if (m_cnt == MB) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % N;
        end
      end else begin
        m_busy = 0;
        m_rr   = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic apply(input logic [N-1:0] v, input logic full);
    @(negedge wclk);
    req_valid  = v;
    fifo_wfull = full;
    req_data   = {dat[3], dat[2], dat[1], dat[0]};
    #1;
    model_outputs();
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst = 1'b1; req_valid = '0; fifo_wfull = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int cyc;
    wrst = 1'b1; req_valid = '0; fifo_wfull = 1'b0; req_data = '0;
    for (int i = 0; i < N; i++) dat[i] = DW'(8'h30 + i);
    @(negedge wclk); #1;
    total++;
    if ({req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id} !== '0) begin
      bad++; $display("FAIL reset_initial got=%h exp=0", {req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id});
    end
    @(negedge wclk); wrst = 1'b0; model_reset();
    for (cyc = 0; cyc < 40; cyc++) begin
      if (m_busy != 0 && m_owner == 2 && m_cnt == 2) break;
      apply(4'hF, 1'b0);
      total++;
      if (grant_valid !== e_gv || grant_id !== 2'(e_gid)) begin
        bad++; $display("FAIL reset_preamble cyc=%0d got=%0b/%0d exp=%0b/%0d", cyc, grant_valid, grant_id, e_gv, e_gid);
      end
      model_update();
    end
    total++;
    if (cyc >= 40) begin
      bad++; $display("FAIL reset_reach_mid_burst got=timeout exp=owner2_cnt2");
    end
    @(negedge wclk);
    wrst = 1'b1; req_valid = '0;
    #1;
    total++;
    if ({req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id} !== '0) begin
      bad++; $display("FAIL reset_async got=%h exp=0", {req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id});
    end
    @(posedge wclk); #1;
    total++;
    if ({req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id} !== '0) begin
      bad++; $display("FAIL reset_edge got=%h exp=0", {req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id});
    end
    @(negedge wclk); wrst = 1'b0; model_reset();
    apply(4'hF, 1'b0);
    total++;
    if (grant_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle_after got=%0b exp=0", grant_valid);
    end
    model_update();
    apply(4'hF, 1'b0);
    total++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL reset_rr_ptr got=%0b/%0d exp=1/0", grant_valid, grant_id);
    end
    model_update();
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < N; i++) dat[i] = DW'((i + 1) * 16);
    for (int c = 0; c < 25; c++) begin
      apply(4'hF, 1'b0);
      total++;
      if ((c % 5) == 0) begin
        if (grant_valid !== 1'b0 || fifo_winc !== 1'b0) begin
          bad++; $display("FAIL rot_bubble c=%0d got=%0b/%0b exp=0/0", c, grant_valid, fifo_winc);
        end
      end else begin
        if (grant_valid !== 1'b1 || grant_id !== 2'((c / 5) % 4) || fifo_winc !== 1'b1 ||
            fifo_wdata !== dat[(c / 5) % 4]) begin
          bad++; $display("FAIL rot_write c=%0d got=%0b/%0d/%0b/%h exp=1/%0d/1/%h",
                          c, grant_valid, grant_id, fifo_winc, fifo_wdata, (c / 5) % 4, dat[(c / 5) % 4]);
        end
      end
      model_update();
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int i = 0; i < N; i++) dat[i] = DW'(8'h50 + i);
    for (int c = 0; c < 12; c++) begin
      if (c >= 3 && c <= 7) apply((c == 5) ? 4'b0100 : 4'b0110, 1'b1);
      else                  apply(4'b0110, 1'b0);
      total++;
      if (c == 0 || c == 10) begin
        if (grant_valid !== 1'b0) begin
          bad++; $display("FAIL stall_bubble c=%0d got=%0b exp=0", c, grant_valid);
        end
      end else if (c >= 3 && c <= 7) begin
        if (fifo_winc !== 1'b0 || req_ready !== 4'b0 || grant_valid !== 1'b1 || grant_id !== 2'd1) begin
          bad++; $display("FAIL stall_hold c=%0d got=%0b/%b/%0b/%0d exp=0/0000/1/1",
                          c, fifo_winc, req_ready, grant_valid, grant_id);
        end
      end else begin
        if (fifo_winc !== 1'b1 || grant_id !== ((c == 11) ? 2'd2 : 2'd1)) begin
          bad++; $display("FAIL stall_write c=%0d got=%0b/%0d exp=1/%0d", c, fifo_winc, grant_id, (c == 11) ? 2 : 1);
        end
      end
      model_update();
    end
  endtask

  task automatic test_early_release();
    do_reset();
    for (int i = 0; i < N; i++) dat[i] = '0;
    apply(4'b1000, 1'b0); model_update();
    dat[3] = 8'hA1;
    apply(4'b1000, 1'b0);
    total++;
    if (grant_id !== 2'd3 || fifo_winc !== 1'b1 || fifo_wdata !== 8'hA1) begin
      bad++; $display("FAIL early_w1 got=%0d/%0b/%h exp=3/1/a1", grant_id, fifo_winc, fifo_wdata);
    end
    model_update();
    dat[3] = 8'hA2;
    apply(4'b1000, 1'b0);
    total++;
    if (fifo_winc !== 1'b1 || fifo_wdata !== 8'hA2) begin
      bad++; $display("FAIL early_w2 got=%0b/%h exp=1/a2", fifo_winc, fifo_wdata);
    end
    model_update();
    dat[3] = 8'h55;
    apply(4'b0000, 1'b0);
    total++;
    if (grant_valid !== 1'b1 || fifo_winc !== 1'b0 || fifo_wdata !== 8'hA2) begin
      bad++; $display("FAIL early_drop got=%0b/%0b/%h exp=1/0/a2", grant_valid, fifo_winc, fifo_wdata);
    end
    model_update();
    apply(4'b1001, 1'b0);
    total++;
    if (grant_valid !== 1'b0) begin
      bad++; $display("FAIL early_idle got=%0b exp=0", grant_valid);
    end
    model_update();
    apply(4'b1001, 1'b0);
    total++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL early_rr_wrap got=%0b/%0d exp=1/0", grant_valid, grant_id);
    end
    model_update();
  endtask

  task automatic test_skip_idle();
    do_reset();
    for (int i = 0; i < N; i++) dat[i] = DW'(8'h70 + i);
    for (int c = 0; c < 12; c++) begin
      apply(4'b1010, 1'b0);
      if (c == 1 || c == 6 || c == 11) begin
        total++;
        if (grant_valid !== 1'b1 || grant_id !== ((c == 6) ? 2'd3 : 2'd1)) begin
          bad++; $display("FAIL skip_grant c=%0d got=%0b/%0d exp=1/%0d", c, grant_valid, grant_id, (c == 6) ? 3 : 1);
        end
      end
      model_update();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic         f;
    do_reset();
    v = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 3) == 0);
      apply(v, f);
      total++;
      if (req_ready !== e_ready || fifo_winc !== e_winc || fifo_wdata !== e_wdata ||
          grant_valid !== e_gv || grant_id !== 2'(e_gid)) begin
        bad++; $display("FAIL rand_cmp c=%0d got=%b/%0b/%h/%0b/%0d exp=%b/%0b/%h/%0b/%0d", c,
                        req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id,
                        e_ready, e_winc, e_wdata, e_gv, e_gid);
      end
      total++;
      if ((fifo_winc && fifo_wfull) || !$onehot0(req_ready)) begin
        bad++; $display("FAIL rand_safety c=%0d got=winc%0b_full%0b_ready%b exp=no_write_when_full_onehot0",
                        c, fifo_winc, fifo_wfull, req_ready);
      end
      model_update();
    end
  endtask

`ifdef ASYNC_FIFO_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    dat[0] = 8'h11;
    for (int c = 0; c < 25; c++) begin
      apply(4'b0001, 1'b0); model_update();
    end
    apply(4'b0000, 1'b0);
    total++;
    if (wr_count[CW-1:0] !== 4'd15 || wr_count[2*CW-1:CW] !== 4'd0) begin
      bad++; $display("FAIL stats_wr_count got=%0d/%0d exp=15/0", wr_count[CW-1:0], wr_count[2*CW-1:CW]);
    end
    model_update();
    apply(4'b0001, 1'b0); model_update();
    for (int c = 0; c < 3; c++) begin
      apply(4'b0001, 1'b1); model_update();
    end
    apply(4'b0000, 1'b0);
    total++;
    if (stall_cnt !== 4'd3) begin
      bad++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt);
    end
    model_update();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_full_stall();
    test_early_release();
    test_skip_idle();
    test_random();
`ifdef ASYNC_FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
